// File: rtl/uart_rx_loader_pkg.sv
// Shared constants and types for the UART image loader.
// Holds the UART frame size, default baud timing, the image size
// shared with the down-sampling core, and the receiver state encoding.
package uart_rx_loader_pkg;

  localparam int unsigned UART_BITS            = 8;
  localparam int unsigned CLK_HZ               = 50_000_000;
  localparam int unsigned BAUD_RATE            = 9600;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD_RATE;
  localparam int unsigned DEFAULT_ADDR_WIDTH   = 16;
  // 256x256 8-bit grey image.
  localparam int unsigned IMG_FRAME_BYTES      = 256 * 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK,
    ST_DONE
  } rx_state_e;

endpackage

// File: rtl/uart_rx_loader_if.sv
// Data-memory write port driven by the UART image loader.
//   mem_we   : one-cycle write strobe
//   mem_addr : write address
//   mem_din  : write data
// master = loader side, slave = memory side.
interface uart_rx_loader_if
  import uart_rx_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [UART_BITS-1:0]  mem_din;

  modport master (output mem_we, output mem_addr, output mem_din);
  modport slave  (input  mem_we, input  mem_addr, input  mem_din);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, baud counter, shift register.
//   clk, rst      : clock, async active-low reset
//   rx_in         : serial line, idles high
//   last_byte     : the next good byte completes the image (go to DONE)
//   byte_valid_c  : good stop bit sampled this cycle; rx_byte holds the byte
//   stop_err_c    : bad stop bit sampled this cycle
//   rx_byte       : assembled byte (LSB first)
module uart_rx_byte
  import uart_rx_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 last_byte,
  output logic                 byte_valid_c,
  output logic                 stop_err_c,
  output logic [UART_BITS-1:0] rx_byte
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W     = $clog2(UART_BITS);
  localparam int unsigned HALF_LAST = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned BIT_LAST  = CLKS_PER_BIT - 1;

  logic             sync1;
  logic             rxs;
  rx_state_e        state;
  rx_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic             tick_half;
  logic             tick_bit;

  // Metastability synchroniser; idles high so reset cannot fake a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
    end
  end

  assign tick_half = (cnt == CNT_W'(HALF_LAST));
  assign tick_bit  = (cnt == CNT_W'(BIT_LAST));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and stop-bit decode.
  always_comb begin
    state_nxt    = state;
    byte_valid_c = 1'b0;
    stop_err_c   = 1'b0;
    unique case (state)
      ST_IDLE:  if (!rxs) state_nxt = ST_START;
      ST_START: if (tick_half) state_nxt = rxs ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick_bit && bit_idx == IDX_W'(UART_BITS - 1)) state_nxt = ST_STOP;
      ST_STOP: begin
        if (tick_bit) begin
          if (rxs) begin
            byte_valid_c = 1'b1;
            state_nxt    = last_byte ? ST_DONE : ST_IDLE;
          end else begin
            stop_err_c = 1'b1;
            state_nxt  = ST_BREAK;
          end
        end
      end
      ST_BREAK: if (rxs) state_nxt = ST_IDLE;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Baud counter restarts on every state change, so DATA samples land
  // one full bit period after the mid-start decision and each one after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      rx_byte <= '0;
    end else begin
      if (state_nxt != state)  cnt <= '0;
      else if (tick_bit)       cnt <= '0;
      else                     cnt <= cnt + CNT_W'(1);

      if (state != ST_DATA) begin
        bit_idx <= '0;
      end else if (tick_bit) begin
        bit_idx <= bit_idx + IDX_W'(1);
        rx_byte <= {rxs, rx_byte[UART_BITS-1:1]};
      end
    end
  end

endmodule

// File: rtl/uart_rx_loader.sv
// Serial image loader: receives UART bytes and writes them sequentially
// into the image data memory, flagging completion to start the core.
//   clk, rst  : clock, async active-low reset
//   rx_in     : serial line, idles high
//   mem       : data-memory write port (mem_we / mem_addr / mem_din)
//   com_over  : full image loaded (sticky until reset)
//   frame_err : a stop-bit error was seen (sticky until reset)
module uart_rx_loader
  import uart_rx_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int unsigned IMG_BYTES    = IMG_FRAME_BYTES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  uart_rx_loader_if.master mem,
  output logic             com_over,
  output logic             frame_err
);

  // One extra bit so a full 2^ADDR_WIDTH image is countable without wrap.
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [CNT_W-1:0]     count;
  logic                 last_byte;
  logic                 byte_valid_c;
  logic                 stop_err_c;
  logic [UART_BITS-1:0] rx_byte;

  assign last_byte = (count == CNT_W'(IMG_BYTES - 1));

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .last_byte    (last_byte),
    .byte_valid_c (byte_valid_c),
    .stop_err_c   (stop_err_c),
    .rx_byte      (rx_byte)
  );

  // Write strobe, address/data hold, and sticky status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem.mem_we   <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_din  <= '0;
      count        <= '0;
      com_over     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      mem.mem_we <= byte_valid_c;
      if (byte_valid_c) begin
        mem.mem_din  <= rx_byte;
        mem.mem_addr <= count[ADDR_WIDTH-1:0];
        count        <= count + CNT_W'(1);
        if (last_byte) com_over <= 1'b1;
      end
      if (stop_err_c) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader with CLKS_PER_BIT=4, IMG_BYTES=4.
module tb_uart_rx_loader;
  import uart_rx_loader_pkg::*;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 4;
  localparam int unsigned NB  = 4;
  // rx fall (just after edge E0) -> mem_we visible after edge E41.
  localparam int unsigned LAT = 41;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_in = 1'b1;
  logic com_over;
  logic frame_err;

  uart_rx_loader_if #(.ADDR_WIDTH(AW)) mem_bus ();

  uart_rx_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_WIDTH   (AW),
    .IMG_BYTES    (NB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .mem       (mem_bus.master),
    .com_over  (com_over),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic          co;
    int unsigned   at;
  } wr_t;
  wr_t wq[$];

  always @(negedge clk)
    if (mem_bus.mem_we === 1'b1)
      wq.push_back('{mem_bus.mem_addr, mem_bus.mem_din, com_over, cyc});

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned t_start = 0;
  int unsigned t0 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_write(input int idx, input logic [AW-1:0] a, input logic [7:0] d,
                             input logic co);
    check($sformatf("wr%0d_present", idx), 32'(wq.size() > idx), 1);
    if (wq.size() > idx) begin
      check($sformatf("wr%0d_addr", idx), 32'(wq[idx].addr), 32'(a));
      check($sformatf("wr%0d_din", idx), 32'(wq[idx].din), 32'(d));
      check($sformatf("wr%0d_com_over", idx), 32'(wq[idx].co), 32'(co));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},   32'(mem_bus.mem_we), 0);
    check({tag, "_addr"}, 32'(mem_bus.mem_addr), 0);
    check({tag, "_din"},  32'(mem_bus.mem_din), 0);
    check({tag, "_co"},   32'(com_over), 0);
    check({tag, "_fe"},   32'(frame_err), 0);
  endtask

  task automatic drive_bit(input logic v);
    rx_in = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    wq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b2;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    idle_bits(2);

    // Full image with 2-bit idle gaps.
    send_byte(8'hA5, 1'b1);
    t0 = t_start;
    idle_bits(2);
    send_byte(8'h3C, 1'b1); idle_bits(2);
    send_byte(8'hFF, 1'b1); idle_bits(2);
    send_byte(8'h00, 1'b1); idle_bits(2);
    check("img_nwrites", 32'(wq.size()), 4);
    check_write(0, 4'd0, 8'hA5, 1'b0);
    check_write(1, 4'd1, 8'h3C, 1'b0);
    check_write(2, 4'd2, 8'hFF, 1'b0);
    check_write(3, 4'd3, 8'h00, 1'b1);
    if (wq.size() > 0) check("first_latency", wq[0].at - t0, LAT);
    check("img_frame_err", 32'(frame_err), 0);

    // Input ignored once the image is complete.
    send_byte(8'h12, 1'b1); idle_bits(3);
    check("done_nwrites", 32'(wq.size()), 4);
    check("done_addr_hold", 32'(mem_bus.mem_addr), 3);
    check("done_din_hold", 32'(mem_bus.mem_din), 0);
    check("done_com_over", 32'(com_over), 1);

    // One-cycle glitch is rejected.
    pulse_reset();
    idle_bits(2);
    rx_in = 1'b0;
    @(posedge clk);
    #1;
    idle_bits(4);
    check("glitch_nwrites", 32'(wq.size()), 0);
    check("glitch_com_over", 32'(com_over), 0);

    // Framing error, then a good byte at address 0.
    send_byte(8'h55, 1'b0);
    idle_bits(2);
    check("ferr_flag", 32'(frame_err), 1);
    check("ferr_nwrites", 32'(wq.size()), 0);
    send_byte(8'h81, 1'b1); idle_bits(2);
    check("after_ferr_nwrites", 32'(wq.size()), 1);
    check_write(0, 4'd0, 8'h81, 1'b0);
    check("ferr_sticky", 32'(frame_err), 1);

    // Back-to-back bytes with no idle gap complete the image.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    idle_bits(2);
    check("b2b_nwrites", 32'(wq.size()), 4);
    check_write(1, 4'd1, 8'h11, 1'b0);
    check_write(2, 4'd2, 8'h22, 1'b0);
    check_write(3, 4'd3, 8'h33, 1'b1);

    // Reset during the 4th data bit of the second byte.
    pulse_reset();
    idle_bits(2);
    send_byte(8'h3C, 1'b1); idle_bits(2);
    b2 = 8'hC6;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b2[i]);
    rx_in = b2[3];
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_idle_outputs("midreset");
    check("midreset_nwrites", 32'(wq.size()), 1);
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    wq.delete();
    idle_bits(4);
    check("post_reset_nwrites", 32'(wq.size()), 0);
    send_byte(8'h77, 1'b1); idle_bits(2);
    check("post_reset_count", 32'(wq.size()), 1);
    check_write(0, 4'd0, 8'h77, 1'b0);
    check("post_reset_com_over", 32'(com_over), 0);
    check("post_reset_frame_err", 32'(frame_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
